// File: rtl/mem_req_arbiter_pkg.sv
// Shared constants and request payload type for the fetch/load-store memory arbiter.
// No logic; imported by the arbiter and its ID FIFO.
// Source IDs double as grant select and response routing tags.
package mem_req_arbiter_pkg;

  localparam logic SRC_INST = 1'b0;
  localparam logic SRC_DATA = 1'b1;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;
  localparam int SIZE_W = 2;

  typedef struct packed {
    logic              wr;
    logic [SIZE_W-1:0] size;
    logic [STRB_W-1:0] wstrb;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/mem_req_arbiter_id_fifo.sv
// In-order FIFO of source IDs for accepted requests awaiting a response.
// Latency: head visible combinationally; push/pop take effect on the next edge.
// Backpressure: push ignored when full (pre-pop count), pop ignored when empty.
module arb_id_fifo #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic push_id,
  input  logic pop,
  output logic head_id,
  output logic full,
  output logic empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [(1<<PTR_W)-1:0] ids;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      cnt;
  logic                  do_push;
  logic                  do_pop;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head_id = ids[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ids    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        ids[wr_ptr] <= push_id;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Two-port (fetch, load/store) arbiter onto one memory request bus; ARB_ROUND_ROBIN_EN selects round-robin.
// Latency: zero-cycle combinational grant; responses routed in order via the ID FIFO.
// Backpressure: grant held while mem_addr_ok is low; mem_req dropped while MAX_OUTSTANDING are in flight.
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [SIZE_W-1:0] inst_size,
  input  logic [STRB_W-1:0] inst_wstrb,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_wdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [SIZE_W-1:0] data_size,
  input  logic [STRB_W-1:0] data_wstrb,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [SIZE_W-1:0] mem_size,
  output logic [STRB_W-1:0] mem_wstrb,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata
);

  req_t inst_pl;
  req_t data_pl;
  req_t mem_pl;
  logic gnt_src;
  logic accept;
  logic pop;
  logic head_id;
  logic fifo_full;
  logic fifo_empty;
  logic lock_vld;
  logic lock_src;
  logic lock_live;
`ifdef ARB_ROUND_ROBIN_EN
  logic rr_prio;
`endif

  assign inst_pl = {inst_wr, inst_size, inst_wstrb, inst_addr, inst_wdata};
  assign data_pl = {data_wr, data_size, data_wstrb, data_addr, data_wdata};

  // A stalled request keeps the bus as long as its requester still holds it.
  assign lock_live = lock_vld && ((lock_src == SRC_DATA) ? data_req : inst_req);

  always_comb begin
    gnt_src = SRC_INST;
    if (lock_live) begin
      gnt_src = lock_src;
    end else if (inst_req && data_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      gnt_src = rr_prio;
`else
      gnt_src = SRC_DATA;
`endif
    end else if (data_req) begin
      gnt_src = SRC_DATA;
    end
  end

  assign mem_req = !reset && !fifo_full && (inst_req || data_req);
  assign mem_pl  = !mem_req ? '0 : (gnt_src == SRC_DATA) ? data_pl : inst_pl;
  assign {mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata} = mem_pl;

  assign accept       = mem_req && mem_addr_ok;
  assign inst_addr_ok = accept && (gnt_src == SRC_INST);
  assign data_addr_ok = accept && (gnt_src == SRC_DATA);

  // Responses with nothing outstanding are dropped on the floor.
  assign pop          = !reset && mem_data_ok && !fifo_empty;
  assign inst_data_ok = pop && (head_id == SRC_INST);
  assign data_data_ok = pop && (head_id == SRC_DATA);
  assign inst_rdata   = inst_data_ok ? mem_rdata : '0;
  assign data_rdata   = data_data_ok ? mem_rdata : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_vld <= 1'b0;
      lock_src <= SRC_INST;
    end else begin
      lock_vld <= mem_req && !mem_addr_ok;
      lock_src <= gnt_src;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_prio <= SRC_INST;
    end else if (accept) begin
      rr_prio <= ~gnt_src;
    end
  end
`endif

  arb_id_fifo #(
    .DEPTH(MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk    (clk),
    .reset  (reset),
    .push   (accept),
    .push_id(gnt_src),
    .pop    (pop),
    .head_id(head_id),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

endmodule

// File: doc/mem_req_arbiter.md
MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_OUTSTANDING, default 2, giving the number of accepted requests awaiting a response (range 1..4).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have ports inst_req/inst_wr, input, 1/1, the fetch-side request valid and write flag.
REQ-005 The block SHALL have ports inst_size/inst_wstrb/inst_addr/inst_wdata, input, 2/4/32/32, the fetch-side payload.
REQ-006 The block SHALL have ports inst_addr_ok/inst_data_ok, output, 1/1, fetch-side request-accepted and response-valid.
REQ-007 The block SHALL have port inst_rdata, output, 32, the fetch-side read data.
REQ-008 The block SHALL have data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata, data_addr_ok, data_data_ok and data_rdata, matching REQ-004..REQ-007 for the load/store side.
REQ-009 The block SHALL have ports mem_req/mem_wr/mem_size/mem_wstrb/mem_addr/mem_wdata, output, 1/1/2/4/32/32, the shared downstream request.
REQ-010 The block SHALL have ports mem_addr_ok/mem_data_ok/mem_rdata, input, 1/1/32, the downstream accept, response valid and read data.

Function
REQ-011 Grant SHALL be combinational: mem_req and payload SHALL equal the granted requester's; zero added latency.
REQ-012 With one requester active, that requester SHALL be granted.
REQ-013 With both active and no lock, the data side SHALL win under fixed priority (see REQ-022).
REQ-014 Acceptance SHALL occur when mem_req && mem_addr_ok; only the granted side SHALL see addr_ok=1, the other 0.
REQ-015 Once mem_req is high without mem_addr_ok, the grant SHALL be locked to that side until acceptance; the payload SHALL not switch sources.
REQ-016 On acceptance, the source ID (0=inst, 1=data) SHALL be pushed into an in-order ID FIFO of depth MAX_OUTSTANDING.
REQ-017 While the FIFO is full, mem_req SHALL be 0, both addr_ok SHALL be 0, and the lock SHALL be released.
REQ-018 On mem_data_ok, the head ID SHALL be popped, and <side>_data_ok=1 with <side>_rdata=mem_rdata SHALL route to that source only; the other side's rdata SHALL be 0.
REQ-019 Simultaneous push and pop SHALL leave the count unchanged; push when full and pop SHALL be legal in the same cycle only if the pop frees the slot (the full check uses pre-pop count).
REQ-020 mem_data_ok with an empty FIFO SHALL be ignored: no data_ok and no pointer change.
REQ-021 Pointers SHALL wrap modulo MAX_OUTSTANDING; the count SHALL saturate at 0..MAX_OUTSTANDING.

Configuration
REQ-022 With ARB_ROUND_ROBIN_EN defined, conflicts SHALL go to the side not granted at the last acceptance (inst first after reset); without it, fixed data priority SHALL apply.

Reset
REQ-023 Reset SHALL empty the FIFO, clear the lock and the round-robin pointer, and force all outputs to 0 asynchronously; in-flight responses SHALL be discarded.

Structure
REQ-024 A shared package SHALL hold the SRC_INST/SRC_DATA constants, the address/data/strobe width constants and the request-payload typedef.
REQ-025 The ID FIFO SHALL be a sub-module, arb_id_fifo.

Verification
REQ-026 Inst-only read at 0x1C000000 with mem_addr_ok=1 and a response 2 cycles later of 0x02C00000 SHALL give inst_addr_ok in the accept cycle and inst_data_ok with inst_rdata=0x02C00000.
REQ-027 Inst and data requesting together without the macro SHALL grant data first and inst on the next accept; responses SHALL return in order to the correct side.
REQ-028 Data request held with mem_addr_ok=0 for 3 cycles, then inst_req rising, SHALL keep mem_addr on the data address until acceptance.
REQ-029 Two accepts without a response (MAX_OUTSTANDING=2) SHALL drive mem_req=0 in cycle 3; mem_data_ok with a new request in the same cycle SHALL be accepted in the following cycle.
REQ-030 mem_data_ok with an empty FIFO SHALL produce no data_ok; reset asserted with 2 outstanding SHALL zero all outputs immediately, and a late mem_data_ok SHALL be ignored.
REQ-031 With ARB_ROUND_ROBIN_EN and both sides requesting continuously, grants SHALL alternate inst, data, inst, data.
